// File: rtl/driver_74hc595_pkg.sv
// Shared constants and types for the 74HC595 lamp-chain driver.
// The optional PWM dimming feature is enabled by defining DRIVER_74HC595_PWM_EN.
package driver_74hc595_pkg;

  // Geometry of the lamp chains: five chains of sixteen bits each.
  localparam int CHAIN_W = 16;
  localparam int N_CHAIN = 5;

  // Frame timing: one LOAD cycle, two cycles per shifted bit, two latch cycles.
  localparam int LOAD_CYCLES  = 1;
  localparam int SHIFT_CYCLES = 2 * CHAIN_W;
  localparam int LATCH_CYCLES = 2;
  localparam int FRAME_CYCLES = LOAD_CYCLES + SHIFT_CYCLES + LATCH_CYCLES;

  // The phase counter must cover every cycle of the SHIFT window.
  localparam int CNT_W = 5;

  // Width of the free-running dimming counter and of the brightness input.
  localparam int PWM_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PWM_W-1:0] pwm_t;

  // Terminal counts for the SHIFT and LATCH windows.
  localparam cnt_t SHIFT_LAST = cnt_t'(SHIFT_CYCLES - 1);
  localparam cnt_t LATCH_LAST = cnt_t'(LATCH_CYCLES - 1);

  // Frame sequencer states; there is deliberately no idle state.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Odd phase counts are the cycles in which SRCLK is high.
  function automatic logic is_clock_phase(input cnt_t cnt);
    return cnt[0];
  endfunction

endpackage

// File: rtl/driver_74hc595_if.sv
// Pin-side bundle between the lamp registers and the 74HC595 chains.
// The brightness input exists only when DRIVER_74HC595_PWM_EN is defined.
interface driver_74hc595_if;
  import driver_74hc595_pkg::*;

  logic [CHAIN_W-1:0] data_0;
  logic [CHAIN_W-1:0] data_1;
  logic [CHAIN_W-1:0] data_2;
  logic [CHAIN_W-1:0] data_3;
  logic [CHAIN_W-1:0] data_4;

`ifdef DRIVER_74HC595_PWM_EN
  pwm_t brightness;
`endif

  logic SER_0;
  logic SER_1;
  logic SER_2;
  logic SER_3;
  logic SER_4;
  logic SRCLK;
  logic RCLK;
  logic OEn;
  logic frame_done;

  // Master side: the lamp-register owner supplies words and watches the pins.
  modport master (
`ifdef DRIVER_74HC595_PWM_EN
    output brightness,
`endif
    output data_0, data_1, data_2, data_3, data_4,
    input  SER_0, SER_1, SER_2, SER_3, SER_4,
    input  SRCLK, RCLK, OEn, frame_done
  );

  // Slave side: the driver consumes words and produces the chain pins.
  modport slave (
`ifdef DRIVER_74HC595_PWM_EN
    input  brightness,
`endif
    input  data_0, data_1, data_2, data_3, data_4,
    output SER_0, SER_1, SER_2, SER_3, SER_4,
    output SRCLK, RCLK, OEn, frame_done
  );

endinterface

// File: rtl/driver_74hc595_chain.sv
// One chain's shadow register and registered serial output.
// The word is captured on load and leaves MSB first, one bit per shift strobe.
module driver_74hc595_chain
  import driver_74hc595_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic               ser_clr,
  input  logic [CHAIN_W-1:0] data,
  output logic               ser
);

  logic [CHAIN_W-1:0] shadow_q;
  logic [CHAIN_W-1:0] shadow_d;
  logic               ser_q;
  logic               ser_d;

  // Next shadow contents and next serial bit. The shadow rotates rather than
  // shifts so every bit stays live; after a full frame it is reloaded anyway.
  // SER is taken from the post-update MSB so it is valid in the cycle right
  // after the load or shift strobe, a full cycle ahead of the SRCLK rise.
  always_comb begin
    shadow_d = shadow_q;
    ser_d    = ser_q;
    if (load) begin
      shadow_d = data;
    end else if (shift) begin
      shadow_d = {shadow_q[CHAIN_W-2:0], shadow_q[CHAIN_W-1]};
    end
    if (ser_clr) begin
      ser_d = 1'b0;
    end else if (load || shift) begin
      ser_d = shadow_d[CHAIN_W-1];
    end
  end

  // Shadow and output registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      ser_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      ser_q    <= ser_d;
    end
  end

  assign ser = ser_q;

endmodule

// File: rtl/driver_74hc595.sv
// Serial-out driver for five daisy-chained 74HC595 lamp chains.
// Sequences LOAD -> SHIFT -> LATCH forever, producing SER/SRCLK/RCLK/OEn.
// Define DRIVER_74HC595_PWM_EN to add brightness dimming on OEn.
module driver_74hc595
  import driver_74hc595_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  driver_74hc595_if.slave  bus
);

  state_e state_q;
  state_e state_d;
  cnt_t   cnt_q;
  cnt_t   cnt_d;

  logic srclk_q;
  logic srclk_d;
  logic rclk_q;
  logic rclk_d;
  logic frame_done_q;
  logic frame_done_d;
  logic latched_q;
  logic latched_d;
  logic oen_q;
  logic oen_d;

`ifdef DRIVER_74HC595_PWM_EN
  pwm_t pwm_cnt_q;
  pwm_t pwm_cnt_d;
`endif

  logic               load_en;
  logic               shift_en;
  logic               ser_clr;
  logic [CHAIN_W-1:0] data_w [N_CHAIN];
  logic               ser_w  [N_CHAIN];

  assign data_w[0] = bus.data_0;
  assign data_w[1] = bus.data_1;
  assign data_w[2] = bus.data_2;
  assign data_w[3] = bus.data_3;
  assign data_w[4] = bus.data_4;

  // Chain strobes: capture during LOAD, advance on each SRCLK-high cycle, and
  // drop SER to 0 on the final advance so it idles low through LATCH.
  assign load_en  = (state_q == LOAD);
  assign shift_en = (state_q == SHIFT) && is_clock_phase(cnt_q);
  assign ser_clr  = shift_en && (cnt_q == SHIFT_LAST);

  for (genvar n = 0; n < N_CHAIN; n++) begin : g_chain
    driver_74hc595_chain u_chain (
      .clk     (clk),
      .reset   (reset),
      .load    (load_en),
      .shift   (shift_en),
      .ser_clr (ser_clr),
      .data    (data_w[n]),
      .ser     (ser_w[n])
    );
  end

  // Frame sequencer: one LOAD cycle, SHIFT_CYCLES of shifting, then two
  // LATCH cycles; the counter is reused as the phase index in each state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          state_d = LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin outputs are decoded from the next state so that they appear,
  // registered, in the same cycle the sequencer enters that phase.
  // RCLK only exists inside LATCH, so SRCLK and RCLK can never overlap and an
  // aborted frame can never be transferred to the lamps.
  always_comb begin
    srclk_d      = (state_d == SHIFT) && is_clock_phase(cnt_d);
    rclk_d       = (state_d == LATCH) && (cnt_d == '0);
    frame_done_d = (state_d == LATCH) && (cnt_d == LATCH_LAST);
    latched_d    = latched_q | rclk_q;
  end

`ifdef DRIVER_74HC595_PWM_EN
  // Lamps light only after a valid latch and only while the free-running
  // dimming counter is below the requested brightness.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + pwm_t'(1);
    oen_d     = ~(latched_d & (pwm_cnt_d < bus.brightness));
  end
`else
  // Lamps stay blanked until the first frame has been latched after reset.
  always_comb begin
    oen_d = ~latched_d;
  end
`endif

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      srclk_q      <= 1'b0;
      rclk_q       <= 1'b0;
      frame_done_q <= 1'b0;
      latched_q    <= 1'b0;
      oen_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      srclk_q      <= srclk_d;
      rclk_q       <= rclk_d;
      frame_done_q <= frame_done_d;
      latched_q    <= latched_d;
      oen_q        <= oen_d;
    end
  end

`ifdef DRIVER_74HC595_PWM_EN
  // Free-running dimming counter, independent of the frame sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`endif

  assign bus.SER_0      = ser_w[0];
  assign bus.SER_1      = ser_w[1];
  assign bus.SER_2      = ser_w[2];
  assign bus.SER_3      = ser_w[3];
  assign bus.SER_4      = ser_w[4];
  assign bus.SRCLK      = srclk_q;
  assign bus.RCLK       = rclk_q;
  assign bus.OEn        = oen_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_driver_74hc595.sv
// Self-checking bench for driver_74hc595 (also builds with DRIVER_74HC595_PWM_EN).
// A cycle-offset reference model predicts every pin; a behavioural 74HC595
// model rebuilds the lamp words from SER/SRCLK/RCLK.
module tb_driver_74hc595;
  import driver_74hc595_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  driver_74hc595_if bus ();

  driver_74hc595 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] din [5];
  logic [3:0]  bright;

  assign bus.data_0 = din[0];
  assign bus.data_1 = din[1];
  assign bus.data_2 = din[2];
  assign bus.data_3 = din[3];
  assign bus.data_4 = din[4];
`ifdef DRIVER_74HC595_PWM_EN
  assign bus.brightness = bright;
`endif

  logic [4:0] ser_vec;
  assign ser_vec = {bus.SER_4, bus.SER_3, bus.SER_2, bus.SER_1, bus.SER_0};

  int checks = 0;
  int errors = 0;

  // Reference-model state: cycle offset since the LOAD after reset release.
  int          off;
  logic [15:0] snap  [5];
  logic [15:0] sr_m  [5];
  logic [15:0] out_m [5];
  logic        prev_srclk;
  logic        prev_rclk;
  logic [4:0]  prev_ser;
  int          rclk_seen;
  logic [15:0] ser0_seq;
  int          first_oen_low;

  // Compare one observed value against the model and count the outcome.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one lamp word.
  task automatic applyStimulus(input int ch, input logic [15:0] val);
    din[ch] = val;
  endtask

  // Predict every pin from the frame offset and compare; also run the 595 model.
  task automatic checkCycle();
    int   p;
    logic lat;
    logic exp_oen;
    logic exp_ser;
    p   = off % FRAME_CYCLES;
    lat = (off >= 34);
`ifdef DRIVER_74HC595_PWM_EN
    exp_oen = !(lat && ((off % 16) < int'(bright)));
`else
    exp_oen = !lat;
`endif
    checkOutput("srclk", 32'(bus.SRCLK), 32'(p >= 2 && p <= 32 && (p % 2) == 0));
    checkOutput("rclk", 32'(bus.RCLK), 32'(p == 33));
    checkOutput("frame_done", 32'(bus.frame_done), 32'(p == 34));
    checkOutput("oen", 32'(bus.OEn), 32'(exp_oen));
    checkOutput("srclk_rclk_excl", 32'(bus.SRCLK & bus.RCLK), 32'd0);
    for (int n = 0; n < 5; n++) begin
      exp_ser = 1'b0;
      if (p >= 1 && p <= 32) exp_ser = snap[n][15 - (p - 1) / 2];
      checkOutput($sformatf("ser_%0d", n), 32'(ser_vec[n]), 32'(exp_ser));
    end
    if (bus.SRCLK) checkOutput("ser_hold", 32'(ser_vec), 32'(prev_ser));
    if (bus.OEn == 1'b0 && first_oen_low < 0) first_oen_low = off;
    if (bus.SRCLK && !prev_srclk) begin
      for (int n = 0; n < 5; n++) sr_m[n] = {sr_m[n][14:0], ser_vec[n]};
      ser0_seq = {ser0_seq[14:0], ser_vec[0]};
    end
    if (bus.RCLK && !prev_rclk) begin
      rclk_seen++;
      for (int n = 0; n < 5; n++) begin
        out_m[n] = sr_m[n];
        checkOutput($sformatf("lamps_%0d", n), 32'(out_m[n]), 32'(snap[n]));
      end
    end
    prev_srclk = bus.SRCLK;
    prev_rclk  = bus.RCLK;
    prev_ser   = ser_vec;
  endtask

  // Advance one clock: snapshot inputs in LOAD, then observe #1 after the edge.
  task automatic tick();
    logic rst_edge;
    rst_edge = reset;
    if (!reset && (off % FRAME_CYCLES) == 0) begin
      for (int n = 0; n < 5; n++) snap[n] = din[n];
    end
    @(posedge clk);
    #1;
    if (rst_edge) off = 0;
    else off++;
    checkCycle();
  endtask

  task automatic runTo(input int target);
    repeat (target - off) tick();
  endtask

  int rclk_before;
  int low_cnt;

  initial begin
    for (int n = 0; n < 5; n++) begin
      din[n]   = 16'h0000;
      snap[n]  = 16'h0000;
      sr_m[n]  = 16'h0000;
      out_m[n] = 16'h0000;
    end
    bright        = 4'd8;
    reset         = 1'b1;
    off           = 0;
    prev_srclk    = 1'b0;
    prev_rclk     = 1'b0;
    prev_ser      = 5'd0;
    rclk_seen     = 0;
    ser0_seq      = 16'h0000;
    first_oen_low = -1;

    // Reset values while reset is held.
    repeat (3) tick();
    checkOutput("rst_oen", 32'(bus.OEn), 32'd1);
    checkOutput("rst_srclk", 32'(bus.SRCLK), 32'd0);
    checkOutput("rst_ser", 32'(ser_vec), 32'd0);

    // Directed frame: A5C3 on chain 0 only.
    applyStimulus(0, 16'hA5C3);
    reset = 1'b0;
    runTo(35);
    checkOutput("ser0_sequence", 32'(ser0_seq), 32'h0000A5C3);
    checkOutput("lamps0_a5c3", 32'(out_m[0]), 32'h0000A5C3);
    checkOutput("lamps1_zero", 32'(out_m[1]), 32'd0);
    checkOutput("lamps4_zero", 32'(out_m[4]), 32'd0);
    checkOutput("rclk_count_f1", 32'(rclk_seen), 32'd1);
    checkOutput("oen_first_low", 32'(first_oen_low), 32'd34);

    // Mid-frame input change only affects the following frame.
    applyStimulus(0, 16'h0000);
    applyStimulus(2, 16'h0001);
    runTo(45);
    applyStimulus(2, 16'hFFFF);
    runTo(70);
    checkOutput("chg_frame_a", 32'(out_m[2]), 32'h00000001);
    runTo(105);
    checkOutput("chg_frame_b", 32'(out_m[2]), 32'h0000FFFF);

    // One-cycle reset at T+20 aborts the frame without a latch.
    for (int n = 0; n < 5; n++) applyStimulus(n, 16'($urandom()));
    runTo(125);
    rclk_before = rclk_seen;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_oen", 32'(bus.OEn), 32'd1);
    for (int n = 0; n < 5; n++) applyStimulus(n, 16'($urandom()));
    runTo(32);
    checkOutput("abort_no_rclk", 32'(rclk_seen), 32'(rclk_before));
    runTo(35);
    checkOutput("abort_fresh_latch", 32'(rclk_seen), 32'(rclk_before + 1));

`ifdef DRIVER_74HC595_PWM_EN
    // Dimming duty over one 16-clock window.
    bright = 4'd4;
    repeat (2) tick();
    low_cnt = 0;
    repeat (16) begin tick(); if (!bus.OEn) low_cnt++; end
    checkOutput("pwm_duty_4", 32'(low_cnt), 32'd4);
    bright = 4'd0;
    repeat (2) tick();
    low_cnt = 0;
    repeat (16) begin tick(); if (!bus.OEn) low_cnt++; end
    checkOutput("pwm_duty_0", 32'(low_cnt), 32'd0);
    bright = 4'd15;
    repeat (2) tick();
    low_cnt = 0;
    repeat (16) begin tick(); if (!bus.OEn) low_cnt++; end
    checkOutput("pwm_duty_15", 32'(low_cnt), 32'd15);
`endif

    // 100 frames of random words changing every cycle.
    runTo(((off / FRAME_CYCLES) + 1) * FRAME_CYCLES);
    rclk_before = rclk_seen;
    repeat (100 * FRAME_CYCLES) begin
      for (int n = 0; n < 5; n++) applyStimulus(n, 16'($urandom()));
`ifdef DRIVER_74HC595_PWM_EN
      if ((off % FRAME_CYCLES) == 0) bright = 4'($urandom_range(0, 15));
`endif
      tick();
    end
    checkOutput("rclk_count_100", 32'(rclk_seen - rclk_before), 32'd100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/driver_74hc595.md
# driver_74hc595

Serial-out driver for five daisy-chained 74HC595 shift-register chains (16 bits each) that drive the front-panel lamps. Each frame snapshots five 16-bit parallel words and shifts them out MSB first on five serial lines with a shared shift clock. It then pulses the storage clock so all chains update together. The block is the output-side counterpart of the panel switch reader and sits in the shell between the core's lamp registers and the board pins.

## Interface
- No parameters; widths are fixed by package constants (CHAIN_W = 16, N_CHAIN = 5).
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data_0 .. data_4  in  16 each  lamp words; sampled only in the LOAD cycle
- SER_0 .. SER_4  out  1 each  serial data to the chain heads
- SRCLK  out  1  shared shift clock; the 74HC595 shifts on its rising edge
- RCLK  out  1  shared storage-register clock; the rising edge transfers the shift register to the outputs
- OEn  out  1  active-low output enable, shared by all chains
- frame_done  out  1  one-cycle pulse, asserted once per completed latch
- brightness  in  4  PWM duty; present only with DRIVER_74HC595_PWM_EN

## Operation
- FSM states: LOAD → SHIFT → LATCH → LOAD, repeating continuously with no idle state.
- **LOAD (1 cycle):** copies data_0..4 into the shadow registers. Inputs may change at any other time without affecting the frame in progress.
- **SHIFT (32 cycles):** a 5-bit counter tracks bit index k = 0..15, with two cycles per bit.
  - Phase 0: SER_n = shadow_n[15-k], SRCLK = 0.
  - Phase 1: SRCLK = 1 and SER_n is held.
- **LATCH (2 cycles):**
  - Cycle 1: SRCLK = 0, RCLK = 1.
  - Cycle 2: RCLK = 0, frame_done = 1.
- After 16 shifts, data_n[15] sits at the last stage (QH) and data_n[0] at the first stage (QA).
- SER_n returns to 0 outside SHIFT.
- **OE gating:** a `latched` flag is cleared by reset and set by the first RCLK pulse.
  - Without PWM: OEn = ~latched.
  - This keeps the lamps blanked until a valid frame has been latched after reset.
- **Reset mid-frame:** all state and outputs return to their reset values, OEn = 1, and the next frame restarts at LOAD. The partially shifted chain contents are never latched.

## Timing
- All outputs are registered; the waveform below is referenced to the LOAD cycle T.
- First reset-deassert cycle is LOAD (T = 0).
- Reset values: SER_0..4 = 0, SRCLK = 0, RCLK = 0, OEn = 1, frame_done = 0. The FSM resets to LOAD and the counters to 0.
- Pin waveform:
  - T+1 .. T+32: shift pattern. SRCLK is high on even offsets T+2, T+4, …, T+32.
  - SER setup and hold are each 1 clk around every SRCLK rising edge.
  - T+33: RCLK = 1.
  - T+34: RCLK = 0, frame_done = 1.
  - T+35: next LOAD.
- Frame period is exactly 35 clk.
- Input-to-lamp latency: data sampled at T appears on the lamps at the RCLK edge seen at T+33.
- In non-PWM builds, OEn falls in the cycle after the first RCLK high, i.e. T+34 of the first frame.
- SRCLK and RCLK are never high in the same cycle.

## Configuration
- **DRIVER_74HC595_PWM_EN defined:**
  - Adds the brightness input and a free-running 4-bit pwm_cnt (reset 0, increments every clk).
  - OEn = ~(latched & (pwm_cnt < brightness)).
  - brightness = 0 keeps the lamps dark; brightness = 15 gives 15/16 on-time.
  - The PWM period is 16 clk and is independent of the frame.
- **Undefined:** no brightness port and no pwm_cnt; OEn = ~latched.

## Structure
- Package driver_74hc595_pkg holds:
  - CHAIN_W = 16, N_CHAIN = 5
  - state encoding LOAD / SHIFT / LATCH
  - SHIFT_CYCLES = 32, FRAME_CYCLES = 35
- Sub-module driver_74hc595_chain, instantiated ×5:
  - one shadow register with load/shift enables
  - outputs SER, with the MSB shifted out first
- The top level owns the FSM, bit counter, SRCLK/RCLK/OEn generation and the PWM logic.

## Test plan
- **Reset release, data_0 = 16'hA5C3, others 0** → SER_0 sequence over 16 SRCLK rises = 1010_0101_1100_0011; SER_1..4 stay 0; RCLK rises once at T+33; a behavioural 595 model's outputs equal 16'hA5C3.
- **Hold reset, then release; count cycles** → OEn = 1 until T+34 of the first frame, then 0; frame_done pulses every 35 clk.
- **Change data_2 from 16'h0001 to 16'hFFFF at T+10** → the current frame latches 16'h0001; the next frame latches 16'hFFFF.
- **Assert reset at T+20 for 1 cycle** → no RCLK pulse from the aborted frame; OEn = 1; a fresh LOAD follows and a clean frame latches 35 clk later.
- **PWM build, brightness = 4, after first latch** → OEn low for exactly 4 of every 16 clk; brightness = 0 → OEn constantly 1.
- **Protocol check across 100 frames** → SRCLK and RCLK never high together; SER stable in the cycle before and the cycle of every SRCLK high.
